// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xor_crc_pkg.sv
// Shared types and defaults for the arbitrated serial XOR-feedback CRC engine.
package gf180mcu_fd_sc_mcu7t5v0__xor_crc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [7:0] DEF_POLY = 8'h07;
  localparam logic [7:0] DEF_INIT = 8'h00;

  // Width of a requester index; never below one bit.
  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rr_arb.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo NREQ.
module gf180mcu_fd_sc_mcu7t5v0__rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [IDW-1:0] cand;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__xor_crc_arb.sv
// Round-robin shared serial CRC engine: grants one requester, shifts its word MSB-first
// through an XOR2 LFSR, and returns the CRC tagged with the owner index.
module gf180mcu_fd_sc_mcu7t5v0__xor_crc_arb
  import gf180mcu_fd_sc_mcu7t5v0__xor_crc_pkg::*;
#(
  parameter int             NREQ = 4,
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = W'(DEF_POLY),
  parameter logic [W-1:0]   INIT = W'(DEF_INIT),
  localparam int            IDW  = idw(NREQ)
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ*W-1:0] D,
  output logic [NREQ-1:0]   GNT,
  output logic              BUSY,
  output logic [W-1:0]      Z,
  output logic              ZV,
  output logic [IDW-1:0]    ZID
);

  localparam int CW = $clog2(W + 1);

  state_t          state, state_d;
  logic [IDW-1:0]  ptr, ptr_d;
  logic [IDW-1:0]  owner, owner_d;
  logic [W-1:0]    sh, sh_d;
  logic [W-1:0]    crc, crc_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [NREQ-1:0] gnt_d;
  logic [W-1:0]    z_d;
  logic            zv_d;
  logic [IDW-1:0]  zid_d;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_idx;
  logic            arb_any;

  logic            fb;
  logic [W-1:0]    crc_shift;

  gf180mcu_fd_sc_mcu7t5v0__rr_arb #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req (REQ),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // One LFSR step: the polynomial is XORed in only when the outgoing bits disagree.
  assign fb        = crc[W-1] ^ sh[W-1];
  assign crc_shift = {crc[W-2:0], 1'b0} ^ (POLY & {W{fb}});

  assign BUSY = (state == SHIFT);

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    owner_d = owner;
    sh_d    = sh;
    crc_d   = crc;
    cnt_d   = cnt;
    gnt_d   = '0;
    z_d     = Z;
    zv_d    = 1'b0;
    zid_d   = ZID;
    unique case (state)
      IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          ptr_d   = arb_idx;
          owner_d = arb_idx;
          sh_d    = D[arb_idx*W +: W];
          crc_d   = INIT;
          cnt_d   = CW'(W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        crc_d = crc_shift;
        sh_d  = {sh[W-2:0], 1'b0};
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          z_d     = crc_shift;
          zv_d    = 1'b1;
          zid_d   = owner;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state <= IDLE;
      ptr   <= IDW'(NREQ - 1);
      owner <= '0;
      sh    <= '0;
      crc   <= '0;
      cnt   <= '0;
      GNT   <= '0;
      Z     <= '0;
      ZV    <= 1'b0;
      ZID   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      owner <= owner_d;
      sh    <= sh_d;
      crc   <= crc_d;
      cnt   <= cnt_d;
      GNT   <= gnt_d;
      Z     <= z_d;
      ZV    <= zv_d;
      ZID   <= zid_d;
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__xor_crc_arb.sv
// Directed bench for the shared CRC engine; expected CRC-8 (poly 07, init 00) values are hand-computed.
module tb_gf180mcu_fd_sc_mcu7t5v0__xor_crc_arb;

  logic        CLK;
  logic        RN;
  logic [3:0]  REQ;
  logic [31:0] D;
  logic [3:0]  GNT;
  logic        BUSY;
  logic [7:0]  Z;
  logic        ZV;
  logic [1:0]  ZID;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  gf180mcu_fd_sc_mcu7t5v0__xor_crc_arb #(
    .NREQ (4),
    .W    (8),
    .POLY (8'h07),
    .INIT (8'h00)
  ) dut (
    .CLK  (CLK),
    .RN   (RN),
    .REQ  (REQ),
    .D    (D),
    .GNT  (GNT),
    .BUSY (BUSY),
    .Z    (Z),
    .ZV   (ZV),
    .ZID  (ZID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    RN  = 1'b0;
    REQ = '0;
    @(negedge CLK);
    RN  = 1'b1;
  endtask

  // Waits for a grant, then follows the job to its ZV cycle, checking timing and result.
  task automatic do_job(input string tag, input logic [31:0] exp_gnt, input logic [31:0] exp_z,
                        input logic [31:0] exp_id, input bit drop, input bit disturb,
                        output int gnt_cyc);
    int waited;
    int n;
    int busy_cnt;
    int extra_gnt;
    waited = 0;
    while (GNT == '0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    gnt_cyc = cyc;
    check({tag, "_gnt"}, 32'(GNT), exp_gnt);
    if (drop) REQ = REQ & ~GNT;
    n = 0;
    busy_cnt = 0;
    extra_gnt = 0;
    while (!ZV && n < 40) begin
      if (BUSY) busy_cnt++;
      @(negedge CLK);
      n++;
      if (GNT != '0) extra_gnt++;
      if (disturb && n == 3) begin
        REQ[3] = 1'b1;
        D[7:0] = 8'hFF;
      end
      if (disturb && n == 4) REQ[3] = 1'b0;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_gnt_during_shift"}, extra_gnt, 0);
    check({tag, "_busy_at_zv"}, 32'(BUSY), 0);
    check({tag, "_z"}, 32'(Z), exp_z);
    check({tag, "_zid"}, 32'(ZID), exp_id);
  endtask

  initial begin
    int g0, g1, g2, g3, g4;
    int zv_seen;
    int waited;
    int late_gnt;

    RN  = 1'b0;
    REQ = '0;
    D   = '0;
    repeat (2) @(negedge CLK);
    check("rst_gnt", 32'(GNT), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_zv", 32'(ZV), 0);
    check("rst_z", 32'(Z), 0);
    check("rst_zid", 32'(ZID), 0);
    RN = 1'b1;

    // Single jobs on requester 0.
    REQ = 4'b0001; D[7:0] = 8'h01;
    do_job("t1", 'b0001, 'h07, 0, 1'b1, 1'b0, g0);
    REQ = 4'b0001; D[7:0] = 8'h80;
    do_job("t2a", 'b0001, 'h89, 0, 1'b1, 1'b0, g0);
    repeat (3) @(negedge CLK);
    check("t2_z_hold", 32'(Z), 'h89);
    check("t2_zv_pulse", 32'(ZV), 0);
    REQ = 4'b0001; D[7:0] = 8'h00;
    do_job("t2b", 'b0001, 'h00, 0, 1'b1, 1'b0, g0);

    // All four held: round robin from a fresh pointer, back-to-back.
    do_reset();
    D = {8'h08, 8'h04, 8'h02, 8'h10};
    REQ = 4'b1111;
    do_job("t3_r0", 'b0001, 'h70, 0, 1'b0, 1'b0, g0);
    do_job("t3_r1", 'b0010, 'h0E, 1, 1'b0, 1'b0, g1);
    do_job("t3_r2", 'b0100, 'h1C, 2, 1'b0, 1'b0, g2);
    do_job("t3_r3", 'b1000, 'h38, 3, 1'b0, 1'b0, g3);
    do_job("t3_r0b", 'b0001, 'h70, 0, 1'b0, 1'b0, g4);
    REQ = '0;
    check("t3_gap01", g1 - g0, 9);
    check("t3_gap12", g2 - g1, 9);
    check("t3_gap23", g3 - g2, 9);
    check("t3_gap30", g4 - g3, 9);

    // Pointer at 1: requester 2 wins before 1.
    REQ = 4'b0010; D[15:8] = 8'h02;
    do_job("t4_set", 'b0010, 'h0E, 1, 1'b1, 1'b0, g0);
    REQ = 4'b0110; D[15:8] = 8'h01; D[23:16] = 8'h80;
    do_job("t4_first", 'b0100, 'h89, 2, 1'b1, 1'b0, g0);
    do_job("t4_second", 'b0010, 'h07, 1, 1'b1, 1'b0, g0);

    // Reset in the middle of a job.
    REQ = 4'b0010; D[15:8] = 8'h55;
    waited = 0;
    while (GNT == '0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check("t5_gnt", 32'(GNT), 'b0010);
    REQ = '0;
    repeat (4) @(negedge CLK);
    RN = 1'b0;
    @(negedge CLK);
    check("t5_rst_gnt", 32'(GNT), 0);
    check("t5_rst_busy", 32'(BUSY), 0);
    check("t5_rst_zv", 32'(ZV), 0);
    check("t5_rst_z", 32'(Z), 0);
    check("t5_rst_zid", 32'(ZID), 0);
    RN = 1'b1;
    zv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (ZV) zv_seen++;
    end
    check("t5_no_zv", zv_seen, 0);
    REQ = 4'b0110; D[15:8] = 8'h01; D[23:16] = 8'h02;
    do_job("t5_ptr_restart", 'b0010, 'h07, 1, 1'b1, 1'b0, g0);
    do_job("t5_req2", 'b0100, 'h0E, 2, 1'b1, 1'b0, g0);

    // Disturbance during SHIFT: REQ3 pulse and owner data change.
    REQ = 4'b0001; D[7:0] = 8'h55;
    do_job("t6", 'b0001, 'hAC, 0, 1'b1, 1'b1, g0);
    late_gnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (GNT != '0) late_gnt++;
    end
    check("t6_pulse_lost", late_gnt, 0);
    check("t6_idle", 32'(BUSY), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
